// File: rtl/lfsr_stream_gen.sv
// -----------------------------------------------------------------------------
// lfsr_stream_gen
//
// Fibonacci LFSR pseudo-random word generator behind a valid/ready stream.
// The LFSR advances only when a word is consumed (valid_o && ready_i), so a
// back-pressuring consumer never loses a word.
//
// Optional feature (compile-time macro):
//   LFSR_STREAM_LOCKUP_RECOVERY_EN
//     defined   : loading seed_i == 0 loads SEED instead and sets the sticky
//                 lockup_o flag (cleared by rst or the next non-zero load).
//     undefined : a zero seed is loaded verbatim; lockup_o is tied to 0.
//
// Parameters:
//   WIDTH     - state/word width (2..32)
//   POLINOM   - feedback tap mask
//   SEED      - reset/recovery seed, must be non-zero
//   STEPS     - single-step shifts chained per advance (1..WIDTH)
//   CNT_WIDTH - transfer counter width
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous reset, active-high
//   en_i        in   run request
//   seed_load_i in   load seed_i this cycle (priority below rst)
//   seed_i      in   seed value
//   ready_i     in   consumer ready
//   valid_o     out  data_o valid
//   data_o      out  current LFSR state word
//   cnt_o       out  transfers since last load/wrap
//   wrap_o      out  one-cycle pulse: sequence returned to the loaded seed
//   lockup_o    out  sticky: an all-zero seed load was replaced by SEED
// -----------------------------------------------------------------------------
module lfsr_stream_gen #(
    parameter int unsigned       WIDTH     = 10,
    parameter logic [WIDTH-1:0]  POLINOM   = 10'b00_1000_0001,
    parameter logic [WIDTH-1:0]  SEED      = WIDTH'(1),
    parameter int unsigned       STEPS     = 1,
    parameter int unsigned       CNT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 seed_load_i,
    input  logic [WIDTH-1:0]     seed_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [WIDTH-1:0]     data_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 wrap_o,
    output logic                 lockup_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_valid;
    logic [WIDTH-1:0]     r_data;
    logic [WIDTH-1:0]     r_seed_q;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_wrap;

    logic                 w_xfer;
    logic [WIDTH-1:0]     w_next;
    logic [WIDTH-1:0]     w_load_val;

    // STEPS single shifts chained combinationally; the new bit enters at the MSB.
    function automatic logic [WIDTH-1:0] f_advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] v;
        v = s;
        for (int unsigned i = 0; i < STEPS; i++) begin
            v = {^(v & POLINOM), v[WIDTH-1:1]};
        end
        return v;
    endfunction

    always_comb begin
        w_xfer = r_valid & ready_i;
        w_next = f_advance(r_data);
    end

`ifdef LFSR_STREAM_LOCKUP_RECOVERY_EN
    logic w_load_zero;
    logic r_lockup;

    always_comb begin
        w_load_zero = (seed_i == '0);
        w_load_val  = w_load_zero ? SEED : seed_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lockup <= 1'b0;
        end else if (seed_load_i) begin
            r_lockup <= w_load_zero;
        end
    end

    assign lockup_o = r_lockup;
`else
    always_comb begin
        w_load_val = seed_i;
    end

    assign lockup_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_data   <= SEED;
            r_seed_q <= SEED;
            r_cnt    <= '0;
            r_wrap   <= 1'b0;
        end else if (seed_load_i) begin
            // A coincident transfer is accepted downstream but neither
            // advances the state nor counts.
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_data   <= w_load_val;
            r_seed_q <= w_load_val;
            r_cnt    <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_xfer) begin
                r_data <= w_next;
                if (w_next == r_seed_q) begin
                    r_wrap <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end

            // valid_o only falls on a transfer, so a dropped en_i parks in
            // DRAIN until the pending word is taken.
            case (r_state)
                ST_IDLE: begin
                    if (en_i) begin
                        r_state <= ST_RUN;
                        r_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!en_i) begin
                        if (w_xfer) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_xfer) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign cnt_o   = r_cnt;
    assign wrap_o  = r_wrap;

endmodule
